// File: rtl/seg7_blink_decoder.sv
// Seven-segment receive monitor: samples A..G, debounces, decodes to a
// character code and classifies it as steady, blinking, blank or unknown.
//
// Ports:
//   clk, reset        : rising-edge clock, async active-high reset
//   A..G              : segment lines, active-high, clk domain
//   char_code[4:0]    : decoded character (31 = unknown, 0 when idle)
//   char_valid        : a recognised character is lit right now
//   blinking          : the character is alternating with blank phases
//   blank             : all segments off
//   pattern_err       : one-cycle pulse when an unknown lit pattern is accepted
module seg7_blink_decoder #(
  parameter int STABLE_CYCLES = 1,
  parameter int MAX_GAP       = 4,
  parameter int MAX_ON        = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       A,
  input  logic       B,
  input  logic       C,
  input  logic       D,
  input  logic       E,
  input  logic       F,
  input  logic       G,
  output logic [4:0] char_code,
  output logic       char_valid,
  output logic       blinking,
  output logic       blank,
  output logic       pattern_err
);

  localparam int RW = $clog2(STABLE_CYCLES + 1);
  localparam int GW = $clog2(MAX_GAP + 2);
  localparam int OW = $clog2(MAX_ON + 2);

  localparam logic [RW-1:0] RUN_ACC = RW'(STABLE_CYCLES - 1);
  localparam logic [RW-1:0] RUN_SAT = RW'(STABLE_CYCLES);
  localparam logic [GW-1:0] GAP_LIM = GW'(MAX_GAP);
  localparam logic [GW-1:0] GAP_SAT = GW'(MAX_GAP + 1);
  localparam logic [OW-1:0] ON_LIM  = OW'(MAX_ON);
  localparam logic [OW-1:0] ON_SAT  = OW'(MAX_ON + 1);
  localparam logic [4:0]    CODE_BAD = 5'd31;

  typedef enum logic [2:0] {
    S_BLANK,
    S_STEADY,
    S_GAP,
    S_BLINK_ON,
    S_BLINK_OFF,
    S_ERROR
  } state_t;

  function automatic logic [4:0] seg_decode(input logic [6:0] p);
    logic [4:0] c;
    case (p)
      7'b1111110: c = 5'd0;
      7'b0110000: c = 5'd1;
      7'b1101101: c = 5'd2;
      7'b1111001: c = 5'd3;
      7'b0110011: c = 5'd4;
      7'b1011011: c = 5'd5;
      7'b1011111: c = 5'd6;
      7'b1110000: c = 5'd7;
      7'b1111111: c = 5'd8;
      7'b1111011: c = 5'd9;
      7'b1110111: c = 5'd10;
      7'b0011111: c = 5'd11;
      7'b1001110: c = 5'd12;
      7'b0111101: c = 5'd13;
      7'b1001111: c = 5'd14;
      7'b1000111: c = 5'd15;
      7'b1100111: c = 5'd16;
      7'b0110111: c = 5'd17;
      7'b0001110: c = 5'd18;
      7'b0111110: c = 5'd19;
      default:    c = CODE_BAD;
    endcase
    return c;
  endfunction

  logic [6:0]    seg_d, seg_q;
  logic [RW-1:0] run_d, run_q;
  state_t        state_d, state_q;
  logic [4:0]    chr_d, chr_q;
  logic [6:0]    errpat_d, errpat_q;
  logic [GW-1:0] gap_d, gap_q;
  logic [OW-1:0] on_d, on_q;
  logic [4:0]    code_d, code_q;
  logic          valid_d, valid_q;
  logic          blink_d, blink_q;
  logic          blank_d, blank_q;
  logic          perr_d, perr_q;

  logic [4:0] dec;
  logic       is_blank;
  logic       is_inv;
  logic       accept;
  logic       acc_blank;
  logic       acc_inv;
  logic       acc_val;
  logic       same;
  logic       gap_to;
  logic       on_to;
  logic       go_err;

  assign seg_d = {A, B, C, D, E, F, G};

  // Run length of seg_q minus one; saturation keeps the
  // acceptance event to a single edge per run.
  always_comb begin
    if (seg_d != seg_q) begin
      run_d = '0;
    end else if (run_q == RUN_SAT) begin
      run_d = run_q;
    end else begin
      run_d = run_q + 1'b1;
    end
  end

  assign dec       = seg_decode(seg_q);
  assign is_blank  = (seg_q == 7'b0000000);
  assign is_inv    = !is_blank && (dec == CODE_BAD);
  assign accept    = (run_q == RUN_ACC);
  assign acc_blank = accept && is_blank;
  assign acc_inv   = accept && is_inv;
  assign acc_val   = accept && !is_blank && !is_inv;
  assign same      = (dec == chr_q);

  // Counter already at its limit means the phase running
  // through this edge is one cycle too long.
  assign gap_to = (gap_q >= GAP_LIM);
  assign on_to  = (on_q >= ON_LIM);

  // Acceptance on an expiry edge is handled as if the timeout
  // had already happened, so the new pattern is never lost.
  always_comb begin
    state_d  = state_q;
    chr_d    = chr_q;
    errpat_d = errpat_q;
    perr_d   = 1'b0;
    go_err   = 1'b0;
    gap_d    = (gap_q == GAP_SAT) ? gap_q : gap_q + 1'b1;
    on_d     = (on_q == ON_SAT) ? on_q : on_q + 1'b1;
    case (state_q)
      S_BLANK: begin
        if (acc_inv) begin
          go_err = 1'b1;
        end else if (acc_val) begin
          state_d = S_STEADY;
          chr_d   = dec;
        end
      end
      S_STEADY: begin
        if (acc_inv) begin
          go_err = 1'b1;
        end else if (acc_blank) begin
          state_d = S_GAP;
          gap_d   = '0;
        end else if (acc_val) begin
          chr_d = dec;
        end
      end
      S_GAP, S_BLINK_OFF: begin
        if (acc_inv) begin
          go_err = 1'b1;
        end else if (acc_val) begin
          if (same && !gap_to) begin
            state_d = S_BLINK_ON;
            on_d    = '0;
          end else begin
            state_d = S_STEADY;
            chr_d   = dec;
          end
        end else if (gap_to) begin
          state_d = S_BLANK;
        end
      end
      S_BLINK_ON: begin
        if (acc_inv) begin
          go_err = 1'b1;
        end else if (acc_blank) begin
          state_d = on_to ? S_GAP : S_BLINK_OFF;
          gap_d   = '0;
        end else if (acc_val && !same) begin
          state_d = S_STEADY;
          chr_d   = dec;
        end else if (on_to) begin
          state_d = S_STEADY;
        end
      end
      S_ERROR: begin
        if (acc_blank) begin
          state_d = S_BLANK;
        end else if (acc_val) begin
          state_d = S_STEADY;
          chr_d   = dec;
        end else if (acc_inv && (seg_q != errpat_q)) begin
          perr_d   = 1'b1;
          errpat_d = seg_q;
        end
      end
      default: begin
        state_d = S_BLANK;
      end
    endcase
    if (go_err) begin
      state_d  = S_ERROR;
      perr_d   = 1'b1;
      errpat_d = seg_q;
    end
  end

  always_comb begin
    code_d  = chr_d;
    valid_d = 1'b0;
    blink_d = 1'b0;
    blank_d = 1'b0;
    case (state_d)
      S_BLANK: begin
        code_d  = 5'd0;
        blank_d = 1'b1;
      end
      S_STEADY: begin
        valid_d = 1'b1;
      end
      S_GAP: begin
        blank_d = 1'b1;
      end
      S_BLINK_ON: begin
        valid_d = 1'b1;
        blink_d = 1'b1;
      end
      S_BLINK_OFF: begin
        blink_d = 1'b1;
        blank_d = 1'b1;
      end
      S_ERROR: begin
        code_d = CODE_BAD;
      end
      default: begin
        code_d  = 5'd0;
        blank_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      seg_q    <= '0;
      run_q    <= '0;
      state_q  <= S_BLANK;
      chr_q    <= '0;
      errpat_q <= '0;
      gap_q    <= '0;
      on_q     <= '0;
      code_q   <= '0;
      valid_q  <= 1'b0;
      blink_q  <= 1'b0;
      blank_q  <= 1'b1;
      perr_q   <= 1'b0;
    end else begin
      seg_q    <= seg_d;
      run_q    <= run_d;
      state_q  <= state_d;
      chr_q    <= chr_d;
      errpat_q <= errpat_d;
      gap_q    <= gap_d;
      on_q     <= on_d;
      code_q   <= code_d;
      valid_q  <= valid_d;
      blink_q  <= blink_d;
      blank_q  <= blank_d;
      perr_q   <= perr_d;
    end
  end

  assign char_code   = code_q;
  assign char_valid  = valid_q;
  assign blinking    = blink_q;
  assign blank       = blank_q;
  assign pattern_err = perr_q;

endmodule

// File: tb/tb_seg7_blink_decoder.sv
// Bench for seg7_blink_decoder: two instances (default and slow
// debounce) against a phase/duration reference model.
module tb_seg7_blink_decoder;

  localparam logic [6:0] PAT_P  = 7'b1100111;
  localparam logic [6:0] PAT_BL = 7'b0000000;
  localparam logic [6:0] PAT_3  = 7'b1111001;
  localparam logic [6:0] PAT_E  = 7'b1001111;
  localparam logic [6:0] PAT_X  = 7'b1010101;
  localparam logic [6:0] PAT_Y  = 7'b0100100;
  localparam logic [6:0] PAT_0  = 7'b1111110;
  localparam logic [6:0] PAT_8  = 7'b1111111;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic [6:0] in0, in1;
  logic [4:0] code0, code1;
  logic       val0, val1, blk0, blk1, bl0, bl1, err0, err1;

  seg7_blink_decoder #(
    .STABLE_CYCLES(1), .MAX_GAP(4), .MAX_ON(64)
  ) dut0 (
    .clk(clk), .reset(reset),
    .A(in0[6]), .B(in0[5]), .C(in0[4]), .D(in0[3]),
    .E(in0[2]), .F(in0[1]), .G(in0[0]),
    .char_code(code0), .char_valid(val0), .blinking(blk0),
    .blank(bl0), .pattern_err(err0)
  );

  seg7_blink_decoder #(
    .STABLE_CYCLES(3), .MAX_GAP(3), .MAX_ON(8)
  ) dut1 (
    .clk(clk), .reset(reset),
    .A(in1[6]), .B(in1[5]), .C(in1[4]), .D(in1[3]),
    .E(in1[2]), .F(in1[1]), .G(in1[0]),
    .char_code(code1), .char_valid(val1), .blinking(blk1),
    .blank(bl1), .pattern_err(err1)
  );

  int ncmp = 0;
  int nerr = 0;

  // Character table in code order; index = character code.
  logic [6:0] tbl [20] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
    7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011,
    7'b1110111, 7'b0011111, 7'b1001110, 7'b0111101, 7'b1001111,
    7'b1000111, 7'b1100111, 7'b0110111, 7'b0001110, 7'b0111110
  };

  int p_s  [2] = '{1, 3};
  int p_g  [2] = '{4, 3};
  int p_on [2] = '{64, 8};

  // Model: hold = shown character (-1 idle), on = lit phase,
  // t0 = edge the current blink phase began.
  int         n;
  int         hold [2];
  bit         on [2];
  bit         blink [2];
  bit         err [2];
  bit         pulse [2];
  logic [6:0] errpat [2];
  logic [6:0] last [2];
  int         runlen [2];
  int         t0 [2];

  function automatic int lookup(input logic [6:0] p);
    for (int i = 0; i < 20; i++) begin
      if (tbl[i] == p) return i;
    end
    return -1;
  endfunction

  task automatic model_reset();
    n = 0;
    for (int k = 0; k < 2; k++) begin
      hold[k] = -1; on[k] = 0; blink[k] = 0; err[k] = 0;
      pulse[k] = 0; errpat[k] = '0; last[k] = '0;
      runlen[k] = 1; t0[k] = 0;
    end
  endtask

  task automatic model_edge(input logic [6:0] s0, input logic [6:0] s1);
    logic [6:0] smp, pat;
    bit acc;
    int c;
    n++;
    for (int k = 0; k < 2; k++) begin
      smp = (k == 0) ? s0 : s1;
      pulse[k] = 0;
      acc = (runlen[k] == p_s[k]);
      pat = last[k];
      if (smp != last[k]) begin
        last[k] = smp; runlen[k] = 1;
      end else begin
        runlen[k]++;
      end
      if (!err[k] && hold[k] >= 0) begin
        if (on[k] && blink[k] && (n - t0[k] > p_on[k])) blink[k] = 0;
        if (!on[k] && (n - t0[k] > p_g[k])) begin
          hold[k] = -1; blink[k] = 0;
        end
      end
      if (acc) begin
        c = lookup(pat);
        if (err[k]) begin
          if (pat == PAT_BL) begin
            err[k] = 0; hold[k] = -1; on[k] = 0; blink[k] = 0;
          end else if (c >= 0) begin
            err[k] = 0; hold[k] = c; on[k] = 1; blink[k] = 0;
          end else if (pat != errpat[k]) begin
            pulse[k] = 1; errpat[k] = pat;
          end
        end else if (pat != PAT_BL && c < 0) begin
          err[k] = 1; pulse[k] = 1; errpat[k] = pat;
          hold[k] = -1; on[k] = 0; blink[k] = 0;
        end else if (pat == PAT_BL) begin
          if (on[k]) begin on[k] = 0; t0[k] = n; end
        end else if (hold[k] == c && !on[k]) begin
          on[k] = 1; blink[k] = 1; t0[k] = n;
        end else if (hold[k] != c) begin
          hold[k] = c; on[k] = 1; blink[k] = 0;
        end
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_model();
    int ec [2];
    bit ev [2], eb [2], ebl [2];
    for (int k = 0; k < 2; k++) begin
      ec[k]  = err[k] ? 31 : (hold[k] < 0 ? 0 : hold[k]);
      ev[k]  = !err[k] && hold[k] >= 0 && on[k];
      eb[k]  = !err[k] && hold[k] >= 0 && blink[k];
      ebl[k] = !err[k] && !(hold[k] >= 0 && on[k]);
    end
    chk("code0", 32'(code0), 32'(ec[0]));
    chk("valid0", 32'(val0), 32'(ev[0]));
    chk("blink0", 32'(blk0), 32'(eb[0]));
    chk("blank0", 32'(bl0), 32'(ebl[0]));
    chk("perr0", 32'(err0), 32'(pulse[0]));
    chk("code1", 32'(code1), 32'(ec[1]));
    chk("valid1", 32'(val1), 32'(ev[1]));
    chk("blink1", 32'(blk1), 32'(eb[1]));
    chk("blank1", 32'(bl1), 32'(ebl[1]));
    chk("perr1", 32'(err1), 32'(pulse[1]));
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_code0"}, 32'(code0), 32'd0);
    chk({tag, "_valid0"}, 32'(val0), 32'd0);
    chk({tag, "_blink0"}, 32'(blk0), 32'd0);
    chk({tag, "_blank0"}, 32'(bl0), 32'd1);
    chk({tag, "_perr0"}, 32'(err0), 32'd0);
    chk({tag, "_code1"}, 32'(code1), 32'd0);
    chk({tag, "_blank1"}, 32'(bl1), 32'd1);
  endtask

  task automatic cyc(input logic [6:0] a, input logic [6:0] b);
    in0 = a;
    in1 = b;
    @(posedge clk);
    #1;
    model_edge(a, b);
    check_model();
  endtask

  task automatic hold_pat(input logic [6:0] p, input int len);
    for (int i = 0; i < len; i++) cyc(p, p);
  endtask

  logic [6:0] pool [8] = '{PAT_P, PAT_BL, PAT_3, PAT_E,
                           PAT_X, PAT_Y, PAT_8, PAT_BL};

  initial begin
    logic [6:0] p;
    int len;
    reset = 1'b1;
    in0 = PAT_BL;
    in1 = PAT_BL;
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("rst");
    model_reset();
    reset = 1'b0;

    for (int i = 0; i < 12; i++) begin
      p = (i % 2 == 0) ? PAT_P : PAT_BL;
      cyc(p, p);
    end

    hold_pat(PAT_3, 20);
    chk("steady3_code0", 32'(code0), 32'd3);
    chk("steady3_valid0", 32'(val0), 32'd1);
    chk("steady3_blink0", 32'(blk0), 32'd0);
    chk("steady3_code1", 32'(code1), 32'd3);

    hold_pat(PAT_P, 3);
    hold_pat(PAT_BL, 6);
    hold_pat(PAT_P, 4);

    for (int i = 0; i < 8; i++) begin
      p = (i % 2 == 0) ? PAT_P : PAT_BL;
      cyc(p, p);
    end
    hold_pat(PAT_E, 5);

    hold_pat(PAT_X, 3);
    hold_pat(PAT_Y, 3);
    hold_pat(PAT_BL, 4);

    hold_pat(PAT_0, 6);
    hold_pat(PAT_8, 2);
    hold_pat(PAT_0, 6);
    chk("glitch_code1", 32'(code1), 32'd0);
    chk("glitch_valid1", 32'(val1), 32'd1);

    for (int r = 0; r < 4; r++) begin
      hold_pat(PAT_P, 4);
      hold_pat(PAT_BL, 3);
    end
    hold_pat(PAT_P, 10);

    for (int i = 0; i < 4; i++) begin
      p = (i % 2 == 0) ? PAT_P : PAT_BL;
      cyc(p, p);
    end
    hold_pat(PAT_P, 70);

    for (int i = 0; i < 6; i++) begin
      p = (i % 2 == 0) ? PAT_P : PAT_BL;
      cyc(p, p);
    end
    reset = 1'b1;
    #2;
    check_reset_vals("midrst");
    model_reset();
    #2;
    reset = 1'b0;
    hold_pat(PAT_P, 6);

    for (int s = 0; s < 300; s++) begin
      p = pool[$urandom_range(0, 7)];
      len = $urandom_range(1, 10);
      hold_pat(p, len);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
